// File: rtl/ex_seq_if.sv
// Handshake bundle between the EX sequencing controller and the pipeline around it.
// master drives the instruction/status side; slave is the controller.
interface ex_seq_if #(
    parameter int RAW   = 4,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [RAW-1:0]   id_rs0;
    logic [RAW-1:0]   id_rs1;
    logic             id_use0;
    logic             id_use1;
    logic             ex_valid;
    logic             ex_load;
    logic [RAW-1:0]   ex_rd;
    logic             ex_we;
    logic             ex_setflags;
    logic             ex_hlt;
    logic             br_ctrl;
    logic             mem_stall;
    logic             stall_pc;
    logic             stall_id;
    logic             stall_ex;
    logic             bubble_ex;
    logic             flush_id;
    logic             pc_sel;
    logic             flag_we;
    logic             halted;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output id_valid, id_rs0, id_rs1, id_use0, id_use1,
               ex_valid, ex_load, ex_rd, ex_we, ex_setflags, ex_hlt,
               br_ctrl, mem_stall,
        input  stall_pc, stall_id, stall_ex, bubble_ex, flush_id,
               pc_sel, flag_we, halted, bubble_cnt
    );

    modport slave (
        input  id_valid, id_rs0, id_rs1, id_use0, id_use1,
               ex_valid, ex_load, ex_rd, ex_we, ex_setflags, ex_hlt,
               br_ctrl, mem_stall,
        output stall_pc, stall_id, stall_ex, bubble_ex, flush_id,
               pc_sel, flag_we, halted, bubble_cnt
    );
endinterface

// File: rtl/ex_seq_ctrl.sv
// Execute-stage sequencing: load-use stall, taken-branch redirect/flush,
// memory-stall freeze, HLT and a saturating bubble counter.
module ex_seq_ctrl #(
    parameter int RAW     = 4,
    parameter int FLUSH_N = 2,
    parameter int CNT_W   = 16
) (
    input logic     clk,
    input logic     rst_n,
    ex_seq_if.slave bus
);
    // The branch cycle is the first squash cycle, so FLUSH holds FLUSH_N-1
    // cycles; the counter is loaded with one less and exits on reading 0.
    localparam int FCW = (FLUSH_N > 2) ? $clog2(FLUSH_N - 1) : 1;
    localparam logic [FCW-1:0] FLOAD = FCW'((FLUSH_N >= 2) ? FLUSH_N - 2 : 0);

    typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

    state_t           state, state_nx;
    logic [FCW-1:0]   fcnt, fcnt_nx;
    logic [CNT_W-1:0] cnt;
    logic             cnt_inc;
    logic             hazard;
    logic             stall_pc, stall_id, stall_ex, bubble_ex;
    logic             flush_id, pc_sel, flag_we, halted;

    assign hazard = bus.ex_valid & bus.ex_load & bus.ex_we & (bus.ex_rd != '0) &
                    bus.id_valid &
                    ((bus.id_use0 & (bus.id_rs0 == bus.ex_rd)) |
                     (bus.id_use1 & (bus.id_rs1 == bus.ex_rd)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            fcnt  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            fcnt  <= fcnt_nx;
            if (cnt_inc && (cnt != '1))
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nx  = state;
        fcnt_nx   = fcnt;
        cnt_inc   = 1'b0;
        stall_pc  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        bubble_ex = 1'b0;
        flush_id  = 1'b0;
        pc_sel    = 1'b0;
        flag_we   = 1'b0;
        halted    = 1'b0;
        // Outputs are forced low while reset is asserted, even mid-flush.
        if (rst_n) begin
            flag_we = bus.ex_valid & bus.ex_setflags & !bus.mem_stall & (state != HALT);
            if (state == HALT) begin
                stall_pc  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
                halted    = 1'b1;
            end else if (bus.mem_stall) begin
                stall_pc = 1'b1;
                stall_id = 1'b1;
                stall_ex = 1'b1;
            end else if (state == FLUSH) begin
                flush_id  = 1'b1;
                bubble_ex = 1'b1;
                cnt_inc   = 1'b1;
                if (fcnt == '0) state_nx = RUN;
                else            fcnt_nx  = fcnt - 1'b1;
            end else if (bus.ex_valid && bus.br_ctrl) begin
                pc_sel    = 1'b1;
                flush_id  = 1'b1;
                bubble_ex = 1'b1;
                cnt_inc   = 1'b1;
                if (FLUSH_N > 1) begin
                    state_nx = FLUSH;
                    fcnt_nx  = FLOAD;
                end
            end else if (bus.ex_valid && bus.ex_hlt) begin
                state_nx = HALT;
            end else if (hazard) begin
                stall_pc  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
                cnt_inc   = 1'b1;
            end
        end
    end

    assign bus.stall_pc   = stall_pc;
    assign bus.stall_id   = stall_id;
    assign bus.stall_ex   = stall_ex;
    assign bus.bubble_ex  = bubble_ex;
    assign bus.flush_id   = flush_id;
    assign bus.pc_sel     = pc_sel;
    assign bus.flag_we    = flag_we;
    assign bus.halted     = halted;
    assign bus.bubble_cnt = cnt;
endmodule
